// File: rtl/sipo_if.sv
// Receive-side serial/parallel bundle between the SPI slave control logic and the SIPO.
// The master side drives the serial line and reads back the parallel word.
interface sipo_if #(
    parameter int WIDTH = 10
);
    logic             MOSI;
    logic [WIDTH-1:0] rx_data;

    modport master (
        output MOSI,
        input  rx_data
    );

    modport slave (
        input  MOSI,
        output rx_data
    );
endinterface

// File: rtl/sipo.sv
// MSB-first serial-in/parallel-out register for the SPI slave receive path.
// Shifts on every clock edge; word framing is left to the external bit counter.
module sipo #(
    parameter int WIDTH = 10
) (
    input  logic  clk,
    input  logic  rst_n,
    sipo_if.slave bus
);

    logic [WIDTH-1:0] shreg;

    // Newest bit enters at bit 0, so the first bit of a word ends up at the top.
    generate
        if (WIDTH == 1) begin : g_single
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    shreg <= '0;
                end else begin
                    shreg <= bus.MOSI;
                end
            end
        end else begin : g_multi
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    shreg <= '0;
                end else begin
                    shreg <= {shreg[WIDTH-2:0], bus.MOSI};
                end
            end
        end
    endgenerate

    assign bus.rx_data = shreg;

endmodule

// File: tb/tb_sipo.sv
// Scoreboard bench for sipo: stimulus queues expected words, a negedge monitor compares them.
module tb_sipo;

    localparam int WIDTH = 10;

    typedef struct {
        logic [WIDTH-1:0] exp;
        string            name;
    } exp_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    exp_t sb_q[$];

    sipo_if #(.WIDTH(WIDTH)) bus ();

    sipo #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    // Monitor: every falling edge, compare rx_data against whatever the stimulus queued.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                checks++;
                if (bus.rx_data !== e.exp) begin
                    errors++;
                    $display("FAIL %s: got %b, required %b", e.name, bus.rx_data, e.exp);
                end
            end
        end
    end

    task automatic push_exp(input logic [WIDTH-1:0] exp, input string name);
        exp_t e;
        e.exp  = exp;
        e.name = name;
        sb_q.push_back(e);
    endtask

    // Called at a falling edge; drives MOSI, takes one rising edge, optionally
    // queues a check for the next falling edge, and returns on that falling edge.
    task automatic shift_bit(input logic b, input bit chk,
                             input logic [WIDTH-1:0] exp, input string name);
        bus.MOSI = b;
        @(posedge clk);
        if (chk) push_exp(exp, name);
        @(negedge clk);
    endtask

    task automatic shift_word(input logic [WIDTH-1:0] w, input string name);
        for (int i = WIDTH - 1; i >= 0; i--) begin
            shift_bit(w[i], (i == 0), w, name);
        end
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [WIDTH-1:0] frame;
        int               drain;

        checks   = 0;
        errors   = 0;
        rst_n    = 1'b0;
        bus.MOSI = 1'b0;
        @(negedge clk);

        // Reset held with clock running and MOSI toggling.
        for (int i = 0; i < 5; i++) begin
            shift_bit(1'($urandom_range(0, 1)), 1'b1, '0, "reset_hold");
        end

        // Single word right after release.
        rst_n = 1'b1;
        shift_word(10'b1011001110, "single_word");

        // One more bit pushes the oldest out.
        shift_bit(1'b1, 1'b1, 10'b0110011101, "overflow");

        // Partial word from reset.
        pulse_reset();
        shift_bit(1'b1, 1'b0, '0, "");
        shift_bit(1'b1, 1'b0, '0, "");
        shift_bit(1'b1, 1'b1, 10'b0000000111, "partial");

        // Asynchronous clear between edges: no rising edge before the check.
        bus.MOSI = 1'b1;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        push_exp('0, "async_clear");
        @(negedge clk);
        rst_n = 1'b1;

        // Reset in the middle of a word leaves no residue.
        for (int i = 0; i < 5; i++) shift_bit(1'b1, 1'b0, '0, "");
        pulse_reset();
        shift_word(10'b0101010101, "midword_reset");

        // Randomised back-to-back frames, MSB first.
        pulse_reset();
        for (int f = 0; f < 100; f++) begin
            frame = WIDTH'($urandom_range(0, (1 << WIDTH) - 1));
            shift_word(frame, $sformatf("random_frame_%0d", f));
        end

        drain = 0;
        while (sb_q.size() != 0 && drain < 10) begin
            @(negedge clk);
            drain++;
        end
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d checks still pending, required 0", sb_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sipo.md
Name: sipo

Overview:
- Serial-in/parallel-out shift register on the receive path of the SPI slave.
- Samples the MOSI line on every rising clock edge and presents the most recent 10 bits in parallel on rx_data.
- Does not track frames: the surrounding SPI control logic counts bit periods and decides when rx_data holds a complete word.

Parameters:
- WIDTH, 10, number of bits held and presented on rx_data. All behaviour below is stated for WIDTH=10; other values scale the same way.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst_n  input  1  asynchronous, active-low reset.
- MOSI  input  1  serial data input from the SPI master.
- rx_data  output  WIDTH  parallel view of the last WIDTH bits sampled. Bit 0 is the newest bit; bit WIDTH-1 is the oldest.

Behaviour:
- Interface: one clock (clk). Reset is asynchronous and active-low (rst_n).
- Reset:
  - rst_n low clears rx_data to all zeros immediately, without waiting for a clock edge.
  - rx_data holds zero while rst_n stays low.
  - The first rising edge of clk after rst_n deasserts performs a normal shift.
- Shift:
  - On every rising edge of clk with rst_n high: rx_data <= {rx_data[WIDTH-2:0], MOSI}.
  - The register shifts left, so the word is received MSB-first.
  - The bit sampled at edge k ends up at rx_data[0]; after WIDTH further edges it has been discarded.
- Latency:
  - A MOSI value set up before a rising edge is visible on rx_data[0] immediately after that edge.
  - A complete word is present after exactly WIDTH consecutive rising edges.
  - The first bit shifted in occupies rx_data[WIDTH-1].
- No enable or frame logic:
  - The register shifts on every clock edge.
  - rx_data is valid as a word only at the edge count chosen by the external bit counter.
  - Between words it continues to shift.
- No internal state beyond the WIDTH-bit register; rx_data is a direct register output with no combinational path from MOSI.
- Back-to-back words: the (WIDTH+1)-th bit discards the oldest bit. There is no gap or idle cycle requirement.
- Reset mid-word: the register clears at once. Shifting resumes from zero after release, and partially received bits are lost.
- Unknown MOSI: an X/Z value on MOSI is shifted in unchanged; it is not masked.
- MOSI must meet setup/hold to the rising edge of clk. Drivers change MOSI on the falling edge.

Test Plan:
- Reset: rst_n=0 with random MOSI toggling and clock running -> rx_data == 10'b0000000000 throughout. Asserting rst_n between clock edges clears the output without an edge.
- Single word: after reset, shift MOSI = 1,0,1,1,0,0,1,1,1,0 on 10 rising edges -> at the following falling edge rx_data == 10'b1011001110.
- Overflow/continuation: after the previous word, shift one more 1 -> rx_data == 10'b0110011101.
- Partial word: from reset, shift 1,1,1 -> rx_data == 10'b0000000111.
- Reset mid-word: shift 5 ones, pulse rst_n low, then shift 10 bits of 10'b0101010101 -> rx_data == 10'b0101010101 with no residue.
- Randomised: 100 frames of 10 random MOSI bits, driven on the falling edge. Compare against a golden {golden, MOSI} model at each word boundary (falling edge after the 10th bit) -> 100 matches, 0 errors.
